// File: rtl/mips_core_pkg.sv
// Shared rename-stage types and sizing for the physical register free list.
package mips_core_pkg;

   localparam int NUM_ARCH_REGS = 32;
   localparam int NUM_PHYS_REGS = 64;
   localparam int TAG_W         = $clog2(NUM_PHYS_REGS);
   localparam int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS;
   localparam int IDX_W         = $clog2(DEPTH);
   // One extra MSB acts as the wrap bit that separates full from empty.
   localparam int PTR_W         = IDX_W + 1;

   typedef logic [TAG_W-1:0] PhysReg;
   typedef logic [PTR_W-1:0] FreeListPtr;

   // Advance a ring pointer: the index wraps DEPTH-1 -> 0 and the wrap bit toggles.
   function automatic FreeListPtr ptr_inc(input FreeListPtr p);
      if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
         return {~p[IDX_W], {IDX_W{1'b0}}};
      end
      return p + FreeListPtr'(1);
   endfunction

endpackage

// File: rtl/phys_reg_free_list_ring.sv
// Tag storage for the free list: DEPTH entries, one write port, one
// asynchronous read port. Reset loads the tags not mapped by the
// architectural registers (NUM_ARCH_REGS .. NUM_PHYS_REGS-1).
module phys_tag_ring
   import mips_core_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  PhysReg           wdata,
   input  logic [IDX_W-1:0] raddr,
   output PhysReg           rdata
);

   PhysReg mem [DEPTH];

   // Reset initialisation of every entry, otherwise a single write per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= PhysReg'(NUM_ARCH_REGS + i);
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Combinational read so the head tag is usable in the same cycle.
   always_comb begin
      rdata = mem[raddr];
   end

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular buffer of unmapped tags with one
// allocation and one free per cycle and a single branch checkpoint of head.
//
// Handshake: alloc is valid/ready -- a tag transfers on an edge where
// alloc_req && alloc_ready && !recover; alloc_tag is stable whenever
// alloc_ready=1. free has no backpressure: a free into a full list is
// dropped and flagged through the sticky overflow_err.
module phys_reg_free_list
   import mips_core_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   alloc_req,
   output logic   alloc_ready,
   output PhysReg alloc_tag,
   input  logic   free_valid,
   input  PhysReg free_tag,
   input  logic   ckpt_save,
   input  logic   ckpt_release,
   input  logic   recover,
   output logic   ckpt_valid,
   output PhysReg free_count,
   output logic   overflow_err
);

   FreeListPtr head;
   FreeListPtr tail;
   FreeListPtr snap;
   FreeListPtr head_next;
   logic       empty;
   logic       full;
   logic       alloc_fire;
   logic       free_fire;

   // Status from the pointers; free_count relies on DEPTH being a power of two
   // so the pointer difference modulo 2*DEPTH is the occupancy.
   always_comb begin
      empty       = (head == tail);
      full        = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
      alloc_ready = !empty;
      alloc_fire  = alloc_req && alloc_ready && !recover;
      free_fire   = free_valid && !full;
      head_next   = alloc_fire ? ptr_inc(head) : head;
      free_count  = PhysReg'(tail - head);
   end

   phys_tag_ring u_ring (
      .clk   (clk),
      .rst   (rst),
      .we    (free_fire),
      .waddr (tail[IDX_W-1:0]),
      .wdata (free_tag),
      .raddr (head[IDX_W-1:0]),
      .rdata (alloc_tag)
   );

   // Head, checkpoint and error flag; recover outranks save and release,
   // save outranks release, and tail moves independently of recovery.
   always_ff @(posedge clk) begin
      if (rst) begin
         head         <= '0;
         tail         <= {1'b1, {IDX_W{1'b0}}};
         snap         <= '0;
         ckpt_valid   <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         if (recover) begin
            if (ckpt_valid) begin
               head       <= snap;
               ckpt_valid <= 1'b0;
            end else begin
               overflow_err <= 1'b1;
            end
         end else begin
            head <= head_next;
            if (ckpt_save) begin
               // Snapshot after this cycle's allocation so the branch keeps its tag.
               snap       <= head_next;
               ckpt_valid <= 1'b1;
            end else if (ckpt_release) begin
               ckpt_valid <= 1'b0;
            end
         end

         if (free_fire) begin
            tail <= ptr_inc(tail);
         end
         if (free_valid && full) begin
            overflow_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: reset, drain, no-bypass on empty,
// checkpoint/recover, overflow, and a wrapping alloc/free stream.
module tb_phys_reg_free_list;

   logic       clk;
   logic       rst;
   logic       alloc_req;
   logic       alloc_ready;
   logic [5:0] alloc_tag;
   logic       free_valid;
   logic [5:0] free_tag;
   logic       ckpt_save;
   logic       ckpt_release;
   logic       recover;
   logic       ckpt_valid;
   logic [5:0] free_count;
   logic       overflow_err;

   int checks;
   int failures;

   logic [5:0] exp_q[$];
   logic       live [64];
   logic [5:0] t;
   logic [5:0] prev_tag;
   logic       prev_valid;

   phys_reg_free_list dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_req    (alloc_req),
      .alloc_ready  (alloc_ready),
      .alloc_tag    (alloc_tag),
      .free_valid   (free_valid),
      .free_tag     (free_tag),
      .ckpt_save    (ckpt_save),
      .ckpt_release (ckpt_release),
      .recover      (recover),
      .ckpt_valid   (ckpt_valid),
      .free_count   (free_count),
      .overflow_err (overflow_err)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      alloc_req    = 1'b0;
      free_valid   = 1'b0;
      free_tag     = '0;
      ckpt_save    = 1'b0;
      ckpt_release = 1'b0;
      recover      = 1'b0;
   endtask

   task automatic drive(input logic a, input logic fv, input logic [5:0] ft,
                        input logic sv, input logic rl, input logic rc);
      alloc_req    = a;
      free_valid   = fv;
      free_tag     = ft;
      ckpt_save    = sv;
      ckpt_release = rl;
      recover      = rc;
   endtask

   // One edge; outputs are sampled 1ns later, then inputs return to idle.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   task automatic fill_model();
      exp_q.delete();
      for (int i = 32; i < 64; i++) exp_q.push_back(6'(i));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      idle();
      #2;

      // Test 1: reset state, then drain all 32 tags in order
      do_reset();
      chk("rst_ready", alloc_ready, 1);
      chk("rst_tag", alloc_tag, 32);
      chk("rst_count", free_count, 32);
      chk("rst_ckpt", ckpt_valid, 0);
      chk("rst_err", overflow_err, 0);
      fill_model();
      for (int i = 0; i < 32; i++) begin
         drive(1, 0, 0, 0, 0, 0);
         chk("t1_ready", alloc_ready, 1);
         chk("t1_tag", alloc_tag, int'(exp_q.pop_front()));
         tick();
      end
      chk("t1_empty_ready", alloc_ready, 0);
      chk("t1_empty_count", free_count, 0);

      // Test 2: free into empty list does not bypass to the allocator
      drive(1, 1, 6'd40, 0, 0, 0);
      chk("t2_no_bypass", alloc_ready, 0);
      tick();
      chk("t2_ready", alloc_ready, 1);
      chk("t2_tag", alloc_tag, 40);
      chk("t2_count", free_count, 1);

      // Test 3: checkpoint on third allocation, two more, recover
      do_reset();
      drive(1, 0, 0, 0, 0, 0); chk("t3_tag32", alloc_tag, 32); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 1, 0, 0); chk("t3_tag34", alloc_tag, 34); tick();
      chk("t3_ckpt_set", ckpt_valid, 1);
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); chk("t3_tag36", alloc_tag, 36); tick();
      chk("t3_count27", free_count, 27);
      drive(0, 0, 0, 0, 0, 1); tick();
      chk("t3_rec_tag", alloc_tag, 35);
      chk("t3_rec_count", free_count, 29);
      chk("t3_rec_ckpt", ckpt_valid, 0);
      chk("t3_rec_err", overflow_err, 0);

      // Test 4: recover with simultaneous alloc_req and free
      do_reset();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 1, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 6'd5, 0, 0, 1); tick();
      chk("t4_tag", alloc_tag, 35);
      chk("t4_count", free_count, 30);
      chk("t4_ckpt", ckpt_valid, 0);
      for (int i = 0; i < 29; i++) begin
         drive(1, 0, 0, 0, 0, 0);
         chk("t4_drain_tag", alloc_tag, 35 + i);
         tick();
      end
      chk("t4_freed_tag", alloc_tag, 5);
      chk("t4_last_count", free_count, 1);

      // Test 5: free while full is dropped and sticks overflow_err
      do_reset();
      drive(0, 1, 6'd7, 0, 0, 0); tick();
      chk("t5_count", free_count, 32);
      chk("t5_err", overflow_err, 1);
      chk("t5_tag_kept", alloc_tag, 32);
      tick(); tick(); tick();
      chk("t5_err_sticky", overflow_err, 1);
      do_reset();
      chk("t5_err_cleared", overflow_err, 0);

      // Test 7: save/release priority, recover over save, recover without snapshot
      do_reset();
      drive(0, 0, 0, 1, 1, 0); tick();
      chk("t7_save_wins", ckpt_valid, 1);
      drive(0, 0, 0, 0, 1, 0); tick();
      chk("t7_release", ckpt_valid, 0);
      drive(1, 0, 0, 1, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      chk("t7_count30", free_count, 30);
      drive(1, 0, 0, 1, 0, 1); tick();
      chk("t7_rec_ckpt", ckpt_valid, 0);
      chk("t7_rec_tag", alloc_tag, 33);
      chk("t7_rec_count", free_count, 31);
      drive(1, 0, 0, 0, 0, 1); tick();
      chk("t7_nockpt_err", overflow_err, 1);
      chk("t7_nockpt_tag", alloc_tag, 33);
      chk("t7_nockpt_count", free_count, 31);

      // Test 8: reset overrides a recovery in the same cycle
      do_reset();
      drive(1, 0, 0, 1, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      rst = 1'b1;
      drive(1, 0, 0, 0, 0, 1); tick();
      rst = 1'b0;
      chk("t8_count", free_count, 32);
      chk("t8_ckpt", ckpt_valid, 0);
      chk("t8_tag", alloc_tag, 32);
      chk("t8_err", overflow_err, 0);

      // Test 6: 70 allocations, each tag freed one cycle later; pointers wrap twice
      do_reset();
      fill_model();
      for (int i = 0; i < 64; i++) live[i] = 1'b0;
      prev_valid = 1'b0;
      prev_tag   = '0;
      for (int c = 0; c < 70; c++) begin
         drive(1, prev_valid, prev_tag, 0, 0, 0);
         chk("t6_ready", alloc_ready, 1);
         t = alloc_tag;
         chk("t6_tag", t, int'(exp_q.pop_front()));
         chk("t6_not_live", live[t], 0);
         live[t] = 1'b1;
         if (prev_valid) begin
            live[prev_tag] = 1'b0;
            exp_q.push_back(prev_tag);
         end
         tick();
         chk("t6_count", free_count, 31);
         prev_tag   = t;
         prev_valid = 1'b1;
      end
      chk("t6_err", overflow_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Allocator and scheduler for the physical register file behind the rename map table.
- Holds all physical tags not currently mapped, in a circular buffer.
- Hands one free tag per cycle to the rename stage for a destination write.
- Takes back one tag per cycle from commit (the old mapping of the retired destination).
- Supports one branch checkpoint: a misprediction returns every tag allocated after the branch in a single cycle.

Parameters:
NUM_ARCH_REGS, 32, architectural registers; tags 0..NUM_ARCH_REGS-1 are mapped at reset.
NUM_PHYS_REGS, 64, physical registers; tag width TAG_W = $clog2(NUM_PHYS_REGS) = 6.
DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS = 32, free-list capacity.

Ports:
clk  in  1  clock; one clock domain; all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
alloc_req  in  1  rename stage needs a destination tag this cycle.
alloc_ready  out  1  free list non-empty; combinational from state registers.
alloc_tag  out  TAG_W  tag at head; valid whenever alloc_ready=1.
free_valid  in  1  commit returns a tag this cycle.
free_tag  in  TAG_W  tag being returned.
ckpt_save  in  1  snapshot head pointer (branch renamed).
ckpt_release  in  1  branch resolved correct; discard snapshot.
recover  in  1  mispredict; roll head back to snapshot.
ckpt_valid  out  1  snapshot held.
free_count  out  TAG_W  number of free tags, 0..DEPTH.
overflow_err  out  1  sticky; a free arrived while the list was full, or a recover arrived with no snapshot.

Behaviour:
- Storage: DEPTH x TAG_W array. head and tail are pointers of $clog2(DEPTH)+1 bits, where the MSB is a wrap bit.
- Status: free_count = tail - head. Empty when head == tail. Full when indices are equal and wrap bits differ.
- Reset (rst=1 at edge):
  - entry i = NUM_ARCH_REGS + i.
  - head = 0; tail = wrap-bit set, index 0 (full).
  - ckpt_valid = 0, overflow_err = 0.
  - Outputs after reset: alloc_ready=1, alloc_tag=32, free_count=32.
  - Reset overrides all other inputs in that cycle, including mid-recovery.
- Allocate: fires when alloc_req && alloc_ready && !recover; head increments at the edge. Latency: tag available in the same cycle (combinational read), consumed at the edge.
- Empty: alloc_ready=0 and alloc_req is ignored. A free arriving in the same cycle does NOT bypass; the tag becomes allocatable the next cycle.
- Free: when free_valid, write free_tag at tail and increment tail.
  - If full, the write is dropped, the pointer is unchanged and overflow_err is set.
  - Simultaneous allocate and free are both applied; free_count is unchanged.
- ckpt_save:
  - Records the head value after this cycle's allocation, so the branch's own allocation is not rolled back.
  - Sets ckpt_valid. A save while ckpt_valid=1 overwrites the snapshot.
- ckpt_release clears ckpt_valid. If asserted with ckpt_save in the same cycle, save wins.
- recover with ckpt_valid=1:
  - head <= snapshot and ckpt_valid <= 0.
  - Any alloc_req that cycle is ignored. A free in the same cycle still applies (tail is independent).
  - free_count next cycle = tail' - snapshot.
- recover with ckpt_valid=0: no state change except overflow_err is set.
- recover has priority over ckpt_save and ckpt_release in the same cycle.
- Pointer wrap: index wraps DEPTH-1 -> 0 and the wrap bit toggles. No other saturation.
- Tag 0 handling: no tag check in this block. The rename stage must not request a tag for writes to $zero.

Decomposition:
- mips_core_pkg gets:
  - constants NUM_ARCH_REGS and NUM_PHYS_REGS;
  - typedef PhysReg = logic [TAG_W-1:0];
  - typedef FreeListPtr.
- Sub-module phys_tag_ring: the DEPTH-entry storage with one write port and one asynchronous read port, plus reset initialisation.
- The top level holds the pointers, checkpoint logic and error flag.

Test Plan:
1. Reset, then alloc_req held 32 cycles -> tags 32,33,...,63 in order; afterwards alloc_ready=0 and free_count=0.
2. Empty list, alloc_req=1 and free_valid=1 with free_tag=40 in the same cycle -> no allocation that cycle. Next cycle alloc_ready=1, alloc_tag=40.
3. After reset, allocate 3 tags (32,33,34), ckpt_save on the 3rd, allocate 35 and 36, then recover -> next cycle alloc_tag=35, free_count=29, ckpt_valid=0.
4. Recover with free_valid=1 (free_tag=5) and alloc_req=1 in the same cycle -> no allocation, head restored, 5 written at tail, free_count = restored count + 1.
5. Free while full (right after reset, free_tag=7) -> free_count stays 32 and overflow_err=1 until rst.
6. Allocate continuously for 70 cycles while freeing each tag 1 cycle later -> pointers wrap twice, free_count stays at 31 in steady state, and no tag is handed out twice while live.
